// File: rtl/deser_fifo_param.sv
`default_nettype none
//==============================================================================
//  Module      : deser_fifo_param
//  Description : Serial-to-parallel front end with an integrated show-ahead
//                word FIFO. Qualified serial bits are collected into
//                WIDTH-bit words. Each completed word is pushed into a
//                DEPTH-entry circular buffer.
//                When the FIFO is full, the FULL_MODE parameter selects the
//                behaviour:
//                  - 0: stall. The completed word is held and status_out
//                       drops until the word can be written.
//                  - 1: drop. The completed word is discarded and the
//                       sticky overflow_out flag is set.
//  Ports       : clock        - system clock, rising edge
//                reset        - asynchronous, active-high
//                data_in      - serial bit
//                write_in     - data_in valid (sampled only while status_out=1)
//                status_out   - 1 = a bit is accepted this cycle
//                dequeue_in   - pop head word (ignored when empty)
//                clear_in     - synchronous flush of deserializer, FIFO,
//                               overflow flag
//                data_out     - head word, 0 when empty
//                len_out      - number of stored words, 0..DEPTH
//                data_ready   - one-cycle pulse after a word entered the FIFO
//                empty_out    - FIFO empty
//                full_out     - FIFO full
//                overflow_out - sticky: a completed word was dropped
//  Revision    : 1.0 - initial release
//==============================================================================
module deser_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1,
   parameter int FULL_MODE = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       data_in,
   input  logic                       write_in,
   output logic                       status_out,
   input  logic                       dequeue_in,
   input  logic                       clear_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH+1)-1:0] len_out,
   output logic                       data_ready,
   output logic                       empty_out,
   output logic                       full_out,
   output logic                       overflow_out
);

   localparam int c_cnt_w = $clog2(WIDTH);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_len_w = $clog2(DEPTH+1);

   localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(WIDTH-1);
   localparam logic [c_len_w-1:0] c_depth     = c_len_w'(DEPTH);
   localparam logic               c_drop_mode = (FULL_MODE != 0);

   typedef enum logic [0:0] {
      ST_SHIFT = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [WIDTH-1:0]     r_shift;
   logic [WIDTH-1:0]     r_hold;
   logic [c_cnt_w-1:0]   r_bit_cnt;
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_len_w-1:0]   r_len;
   logic                 r_overflow;
   logic                 r_data_ready;
   logic [WIDTH-1:0]     r_mem [DEPTH];

   logic [WIDTH-1:0]     w_shift_nxt;
   logic                 w_accept;
   logic                 w_word_done;
   logic                 w_push_ok;
   logic                 w_push_shift;
   logic                 w_push_hold;
   logic                 w_hold_load;
   logic                 w_drop;
   logic                 w_push;
   logic                 w_pop;
   logic [WIDTH-1:0]     w_push_data;

   // The value the shift register takes when the current bit is accepted.
   // On the last bit, this value is the completed word.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_shift_nxt = {r_shift[WIDTH-2:0], data_in};
      end else begin : g_lsb_first
         assign w_shift_nxt = {data_in, r_shift[WIDTH-1:1]};
      end
   endgenerate

   assign status_out  = (r_state == ST_SHIFT);
   assign w_accept    = write_in & status_out;
   assign w_word_done = w_accept & (r_bit_cnt == c_last_bit);
   // A pop on the same edge frees a slot, even when the FIFO is full.
   assign w_push_ok   = !full_out | (dequeue_in & !empty_out);

   // Next-state logic and per-edge actions. Clear overrides everything.
   always_comb begin
      w_state_nxt  = r_state;
      w_push_shift = 1'b0;
      w_push_hold  = 1'b0;
      w_hold_load  = 1'b0;
      w_drop       = 1'b0;
      if (clear_in) begin
         w_state_nxt = ST_SHIFT;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               if (w_word_done) begin
                  if (w_push_ok) begin
                     w_push_shift = 1'b1;
                  end else if (c_drop_mode) begin
                     w_drop = 1'b1;
                  end else begin
                     w_hold_load = 1'b1;
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (w_push_ok) begin
                  w_push_hold = 1'b1;
                  w_state_nxt = ST_SHIFT;
               end
            end
            default: w_state_nxt = ST_SHIFT;
         endcase
      end
   end

   assign w_push      = w_push_shift | w_push_hold;
   assign w_push_data = w_push_hold ? r_hold : w_shift_nxt;
   assign w_pop       = dequeue_in & !empty_out & !clear_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_SHIFT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_shift      <= '0;
         r_hold       <= '0;
         r_bit_cnt    <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_len        <= '0;
         r_overflow   <= 1'b0;
         r_data_ready <= 1'b0;
      end else if (clear_in) begin
         r_shift      <= '0;
         r_hold       <= '0;
         r_bit_cnt    <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_len        <= '0;
         r_overflow   <= 1'b0;
         r_data_ready <= 1'b0;
      end else begin
         if (w_accept) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
         end
         if (w_hold_load) begin
            r_hold <= w_shift_nxt;
         end
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_len <= r_len + 1'b1;
            2'b01:   r_len <= r_len - 1'b1;
            default: r_len <= r_len;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         r_data_ready <= w_push;
      end
   end

   // The storage array needs no reset: empty_out masks stale contents.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   assign len_out      = r_len;
   assign empty_out    = (r_len == '0);
   assign full_out     = (r_len == c_depth);
   assign data_out     = empty_out ? '0 : r_mem[r_rd_ptr];
   assign data_ready   = r_data_ready;
   assign overflow_out = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_deser_fifo_param.sv
`default_nettype none
//==============================================================================
//  Module      : tb_deser_fifo_param
//  Description : Directed self-checking bench for deser_fifo_param.
//                It drives one serial stream into three instances:
//                  - a: MSB-first, stall
//                  - b: LSB-first, stall
//                  - c: MSB-first, drop
//  Revision    : 1.0 - initial release
//==============================================================================
module tb_deser_fifo_param;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       data_in = 1'b0;
   logic       write_in = 1'b0;
   logic       dequeue_in = 1'b0;
   logic       clear_in = 1'b0;

   logic       a_status, a_rdy, a_empty, a_full, a_ovf;
   logic [7:0] a_data;
   logic [2:0] a_len;
   logic       b_status, b_rdy, b_empty, b_full, b_ovf;
   logic [7:0] b_data;
   logic [2:0] b_len;
   logic       c_status, c_rdy, c_empty, c_full, c_ovf;
   logic [7:0] c_data;
   logic [2:0] c_len;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   deser_fifo_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .FULL_MODE(0)) dut_a (
      .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
      .status_out(a_status), .dequeue_in(dequeue_in), .clear_in(clear_in),
      .data_out(a_data), .len_out(a_len), .data_ready(a_rdy),
      .empty_out(a_empty), .full_out(a_full), .overflow_out(a_ovf));

   deser_fifo_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .FULL_MODE(0)) dut_b (
      .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
      .status_out(b_status), .dequeue_in(dequeue_in), .clear_in(clear_in),
      .data_out(b_data), .len_out(b_len), .data_ready(b_rdy),
      .empty_out(b_empty), .full_out(b_full), .overflow_out(b_ovf));

   deser_fifo_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .FULL_MODE(1)) dut_c (
      .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
      .status_out(c_status), .dequeue_in(dequeue_in), .clear_in(clear_in),
      .data_out(c_data), .len_out(c_len), .data_ready(c_rdy),
      .empty_out(c_empty), .full_out(c_full), .overflow_out(c_ovf));

   // LSB-first instance: the first bit sent lands in bit 0.
   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Send the n leading bits of seq, starting with seq[7].
   task automatic send_bits(input logic [7:0] seq, input int n);
      for (int i = 0; i < n; i++) begin
         data_in  = seq[7-i];
         write_in = 1'b1;
         step();
      end
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- reset state
      #3;
      chk("rst_status", a_status, 1);
      chk("rst_empty",  a_empty, 1);
      chk("rst_len",    a_len, 0);
      chk("rst_data",   a_data, 0);
      chk("rst_rdy",    a_rdy, 0);
      chk("rst_full",   a_full, 0);
      chk("rst_ovf",    c_ovf, 0);
      step();
      reset = 1'b0;

      // ---- reset mid-word discards the partial word
      send_bits(8'hE0, 3);
      #2 reset = 1'b1;
      #1;
      chk("midrst_len",    a_len, 0);
      chk("midrst_empty",  a_empty, 1);
      chk("midrst_status", a_status, 1);
      #2 reset = 1'b0;
      step();

      // ---- bits 1,0,1,0,0,1,0,1 -> A5 in both bit orders
      send_bits(8'hA5, 8);
      chk("a5_rdy",    a_rdy, 1);
      chk("a5_data_a", a_data, 8'hA5);
      chk("a5_len",    a_len, 1);
      chk("a5_data_b", b_data, 8'hA5);
      step();
      chk("a5_rdy_drop", a_rdy, 0);

      // ---- pop to empty, then dequeue on empty
      dequeue_in = 1'b1;
      step();
      chk("pop_len",   a_len, 0);
      chk("pop_empty", a_empty, 1);
      step();
      dequeue_in = 1'b0;
      chk("pop_empty_len",  a_len, 0);
      chk("pop_empty_data", a_data, 0);

      // ---- fill to 4, then fifth word on a full FIFO
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      send_bits(8'h33, 8);
      send_bits(8'h44, 8);
      chk("fill_len",  a_len, 4);
      chk("fill_full", a_full, 1);
      chk("fill_head_b", b_data, rev8(8'h11));
      send_bits(8'h55, 8);
      chk("stall_status_a", a_status, 0);
      chk("stall_status_b", b_status, 0);
      chk("stall_len_a",    a_len, 4);
      chk("stall_rdy_a",    a_rdy, 0);
      chk("drop_ovf_c",     c_ovf, 1);
      chk("drop_len_c",     c_len, 4);
      chk("drop_status_c",  c_status, 1);

      dequeue_in = 1'b1;
      step();
      chk("hold_push_len",    a_len, 4);
      chk("hold_push_status", a_status, 1);
      chk("hold_push_rdy",    a_rdy, 1);
      chk("hold_head_a",      a_data, 8'h22);
      chk("hold_head_b",      b_data, rev8(8'h22));
      chk("drop_pop_len_c",   c_len, 3);
      chk("drop_head_c",      c_data, 8'h22);
      chk("drop_rdy_c",       c_rdy, 0);
      step();
      chk("drain1_a", a_data, 8'h33);
      chk("drain1_c", c_data, 8'h33);
      step();
      chk("drain2_a", a_data, 8'h44);
      chk("drain2_c", c_data, 8'h44);
      step();
      chk("drain3_a", a_data, 8'h55);
      chk("drain3_b", b_data, rev8(8'h55));
      chk("drain3_c_empty", c_empty, 1);
      chk("drain3_c_data",  c_data, 0);
      step();
      dequeue_in = 1'b0;
      chk("drain4_a_empty", a_empty, 1);
      chk("drain4_c_len",   c_len, 0);
      chk("ovf_sticky_c",   c_ovf, 1);

      // ---- push and pop on the same edge at len 2
      send_bits(8'h66, 8);
      send_bits(8'h77, 8);
      chk("len2_a", a_len, 2);
      send_bits(8'h96, 7);
      data_in    = 1'b0;
      write_in   = 1'b1;
      dequeue_in = 1'b1;
      step();
      write_in   = 1'b0;
      dequeue_in = 1'b0;
      chk("pushpop_len_a",  a_len, 2);
      chk("pushpop_len_c",  c_len, 2);
      chk("pushpop_rdy_a",  a_rdy, 1);
      chk("pushpop_head_a", a_data, 8'h77);
      chk("pushpop_head_b", b_data, rev8(8'h77));

      // ---- clear at len 3 with overflow set and a partial word pending
      send_bits(8'h5A, 8);
      chk("preclr_len_c", c_len, 3);
      chk("preclr_ovf_c", c_ovf, 1);
      send_bits(8'hF0, 3);
      clear_in   = 1'b1;
      write_in   = 1'b1;
      data_in    = 1'b1;
      dequeue_in = 1'b1;
      step();
      clear_in   = 1'b0;
      write_in   = 1'b0;
      data_in    = 1'b0;
      dequeue_in = 1'b0;
      chk("clr_len_a",    a_len, 0);
      chk("clr_empty_a",  a_empty, 1);
      chk("clr_data_a",   a_data, 0);
      chk("clr_rdy_a",    a_rdy, 0);
      chk("clr_status_a", a_status, 1);
      chk("clr_len_c",    c_len, 0);
      chk("clr_ovf_c",    c_ovf, 0);

      // ---- a fresh word after clear starts from bit 0
      send_bits(8'hC6, 8);
      chk("postclr_data_a", a_data, 8'hC6);
      chk("postclr_data_b", b_data, rev8(8'hC6));
      chk("postclr_len_a",  a_len, 1);
      chk("postclr_rdy_a",  a_rdy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
